// File: rtl/alu_pkg.sv
// Shared opcode fields, flag indices, FSM encoding and per-class flag masks
// for the instruction sequencer in front of the register file and ALU.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 4;
  localparam int OPC_W   = 8;
  localparam int FLAG_W  = 5;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Major op field, instr[15:12]
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;

  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_NOT  = 4'b0100;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  // Register-amount shifts under OP_SHIFT
  localparam logic [3:0] EXT_LSH  = 4'b0100;
  localparam logic [3:0] EXT_ASHU = 4'b0110;
  localparam logic [3:0] EXT_ROT  = 4'b1000;
  localparam logic [3:0] EXT_ROTC = 4'b1001;

  localparam logic [FLAG_W-1:0] MASK_ARITH = 5'b10111;
  localparam logic [FLAG_W-1:0] MASK_ADDU  = 5'b11110;
  localparam logic [FLAG_W-1:0] MASK_ADDC  = 5'b10100;
  localparam logic [FLAG_W-1:0] MASK_CMP   = 5'b01011;
  localparam logic [FLAG_W-1:0] MASK_LOGIC = 5'b00011;
  localparam logic [FLAG_W-1:0] MASK_NONE  = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    IMM_REG   = 2'd0,
    IMM_SEXT  = 2'd1,
    IMM_ZEXT  = 2'd2,
    IMM_SHIFT = 2'd3
  } imm_sel_t;

  typedef struct packed {
    imm_sel_t          imm_sel;
    logic              writes_back;
    logic [FLAG_W-1:0] flag_mask;
    logic              illegal;
  } dec_t;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  // Shift-immediate amount; the s bit turns a left shift into a right shift
  function automatic logic [DATA_W-1:0] shift_amount(input logic s, input logic [3:0] amt);
    logic [DATA_W-1:0] v;
    v = {{(DATA_W-4){1'b0}}, amt};
    return s ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction classifier: operand source, writeback enable,
// PSR flag mask and illegal-opcode detection.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] instr_i,
  output dec_t              dec_o
);

  logic [3:0] op;
  logic [3:0] ext;
  logic       unused_fields;

  assign op            = instr_i[15:12];
  assign ext           = instr_i[7:4];
  assign unused_fields = ^{instr_i[11:8], instr_i[3:0]};

  always_comb begin
    dec_o         = '0;
    dec_o.illegal = 1'b1;
    case (op)
      OP_REG: begin
        case (ext)
          EXT_NOP: dec_o.illegal = 1'b0;
          EXT_AND, EXT_OR, EXT_XOR, EXT_NOT: begin
            dec_o.illegal     = 1'b0;
            dec_o.writes_back = 1'b1;
            dec_o.flag_mask   = MASK_LOGIC;
          end
          EXT_ADD, EXT_SUB: begin
            dec_o.illegal     = 1'b0;
            dec_o.writes_back = 1'b1;
            dec_o.flag_mask   = MASK_ARITH;
          end
          EXT_ADDU: begin
            dec_o.illegal     = 1'b0;
            dec_o.writes_back = 1'b1;
            dec_o.flag_mask   = MASK_ADDU;
          end
          EXT_ADDC: begin
            dec_o.illegal     = 1'b0;
            dec_o.writes_back = 1'b1;
            dec_o.flag_mask   = MASK_ADDC;
          end
          EXT_CMP: begin
            dec_o.illegal   = 1'b0;
            dec_o.flag_mask = MASK_CMP;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        dec_o.illegal     = 1'b0;
        dec_o.writes_back = 1'b1;
        dec_o.flag_mask   = MASK_ARITH;
        dec_o.imm_sel     = IMM_SEXT;
      end
      OP_ADDUI: begin
        dec_o.illegal     = 1'b0;
        dec_o.writes_back = 1'b1;
        dec_o.flag_mask   = MASK_ADDU;
        dec_o.imm_sel     = IMM_ZEXT;
      end
      OP_ADDCI: begin
        dec_o.illegal     = 1'b0;
        dec_o.writes_back = 1'b1;
        dec_o.flag_mask   = MASK_ADDC;
        dec_o.imm_sel     = IMM_ZEXT;
      end
      OP_CMPI: begin
        dec_o.illegal   = 1'b0;
        dec_o.flag_mask = MASK_CMP;
        dec_o.imm_sel   = IMM_SEXT;
      end
      OP_SHIFT: begin
        casez (ext)
          4'b000?, 4'b001?, 4'b101?: begin
            dec_o.illegal     = 1'b0;
            dec_o.writes_back = 1'b1;
            dec_o.flag_mask   = MASK_LOGIC;
            dec_o.imm_sel     = IMM_SHIFT;
          end
          EXT_LSH, EXT_ASHU, EXT_ROT, EXT_ROTC: begin
            dec_o.illegal     = 1'b0;
            dec_o.writes_back = 1'b1;
            dec_o.flag_mask   = MASK_LOGIC;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-cycle instruction sequencer: register read, ALU execute, writeback
// and masked PSR update, one instruction in flight at a time.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int BIT_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int OPCODE_WIDTH   = 8,
  parameter int FLAG_WIDTH     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [BIT_WIDTH-1:0]      instr,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr_a,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr_b,
  input  logic [BIT_WIDTH-1:0]      rf_rdata_a,
  input  logic [BIT_WIDTH-1:0]      rf_rdata_b,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode,
  output logic [BIT_WIDTH-1:0]      alu_rdest,
  output logic [BIT_WIDTH-1:0]      alu_rsrc_imm,
  input  logic [BIT_WIDTH-1:0]      alu_result,
  input  logic [FLAG_WIDTH-1:0]     alu_flags,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [BIT_WIDTH-1:0]      rf_wdata,
  output logic [FLAG_WIDTH-1:0]     psr,
  output logic                      busy,
  output logic                      done,
  output logic                      illegal
);

  state_t                    state_q;
  logic [BIT_WIDTH-1:0]      ir_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      illegal_q;
  logic                      rf_we_q;
  logic [REG_ADDR_WIDTH-1:0] raddr_a_q;
  logic [REG_ADDR_WIDTH-1:0] raddr_b_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic [BIT_WIDTH-1:0]      res_q;
  logic [FLAG_WIDTH-1:0]     flag_q;
  logic [FLAG_WIDTH-1:0]     mask_q;
  logic [FLAG_WIDTH-1:0]     psr_q;

  dec_t                      dec;
  logic                      in_exec;
  logic [BIT_WIDTH-1:0]      operand_b;

  alu_op_decode u_decode (
    .instr_i (ir_q),
    .dec_o   (dec)
  );

  always_comb begin
    operand_b = rf_rdata_b;
    case (dec.imm_sel)
      IMM_SEXT:  operand_b = sext8(ir_q[7:0]);
      IMM_ZEXT:  operand_b = {{(BIT_WIDTH-8){1'b0}}, ir_q[7:0]};
      IMM_SHIFT: operand_b = shift_amount(ir_q[4], ir_q[3:0]);
      default:   operand_b = rf_rdata_b;
    endcase
  end

  // ALU inputs are only meaningful in EXEC; they read as zero otherwise
  assign in_exec      = (state_q == ST_EXEC);
  assign alu_opcode   = in_exec ? {ir_q[15:12], ir_q[7:4]} : '0;
  assign alu_rdest    = in_exec ? rf_rdata_a : '0;
  assign alu_rsrc_imm = in_exec ? operand_b : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      waddr_q   <= '0;
      res_q     <= '0;
      flag_q    <= '0;
      mask_q    <= '0;
      psr_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && ready_q) begin
            ir_q      <= instr;
            raddr_a_q <= instr[11:8];
            raddr_b_q <= instr[3:0];
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_EXEC;
        ST_EXEC: begin
          res_q     <= alu_result;
          flag_q    <= alu_flags & dec.flag_mask;
          mask_q    <= dec.flag_mask;
          rf_we_q   <= dec.writes_back;
          waddr_q   <= ir_q[11:8];
          done_q    <= 1'b1;
          illegal_q <= dec.illegal;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          psr_q   <= (psr_q & ~mask_q) | (flag_q & mask_q);
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign rf_raddr_a  = raddr_a_q;
  assign rf_raddr_b  = raddr_b_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = res_q;
  assign psr         = psr_q;

endmodule
